// File: rtl/router_pkg.sv
// Shared constants and helpers for the instruction router.
// Channel indices and FIFO pointer sizing.
package router_pkg;

  localparam int CH_SELF  = 0;
  localparam int CH_LEFT  = 1;
  localparam int CH_RIGHT = 2;

  // Index bits plus one lap bit so full and empty differ.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/route_fifo.sv
// Per-channel instruction FIFO with valid/ready style push/pop.
// Head output reads as zero while empty.
module route_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset drops queued words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/instr_router.sv
// Instruction dispatcher: unicast/broadcast fan-out into
// per-channel FIFOs, illegal selects dropped with a pulse.
module instr_router
  import router_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic [WIDTH-1:0]          in_instr,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_instr,
  output logic                      sel_err
);

  localparam logic [SEL_W:0] N_CH = (SEL_W+1)'(CHANNELS);

  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] full;
  logic                sel_legal;
  logic                sel_full;
  logic                accept;

  assign sel_legal = ({1'b0, in_sel} < N_CH);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  // Ready from registered full flags; push fan-out on accept.
  always_comb begin
    sel_full = 1'b0;
    push     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_sel == SEL_W'(c)) sel_full = full[c];
    end
    if (in_bcast)       in_ready = ~|full;
    else if (sel_legal) in_ready = !sel_full;
    else                in_ready = 1'b1;
    accept = in_valid && in_ready;
    for (int c = 0; c < CHANNELS; c++) begin
      push[c] = accept
             && (in_bcast || (sel_legal && in_sel == SEL_W'(c)));
    end
  end

  // One pulse per dropped illegal word.
  always_ff @(posedge clk) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= in_valid && !in_bcast && !sel_legal;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    route_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .din   (in_instr),
      .pop   (pop[c]),
      .dout  (out_instr[c*WIDTH +: WIDTH]),
      .empty (empty[c]),
      .full  (full[c])
    );
  end

endmodule

// File: doc/instr_router.md
# instr_router

Parametrised instruction dispatcher that generalises the self/left/right instruction fan-out to `CHANNELS` destinations. Each channel has its own `DEPTH`-entry FIFO with valid/ready handshakes on both sides, so a slow neighbour back-pressures only its own traffic. It also adds a broadcast mode and a one-cycle error pulse for illegal selects. It sits between the instruction source and the per-node receivers (self, left, right, …) of the interconnect.

## Interface
- `WIDTH`, 32, instruction width in bits
- `CHANNELS`, 3, number of destinations; channel 0 = self, 1 = left, 2 = right
- `DEPTH`, 4, entries per channel FIFO; power of two, ≥2
- `SEL_W`, `$clog2(CHANNELS)` (min 1), select width
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `in_valid`  in  1  source offers `in_instr`
- `in_ready`  out  1  router accepts this cycle
- `in_sel`  in  SEL_W  destination channel
- `in_bcast`  in  1  write to all channels; `in_sel` ignored
- `in_instr`  in  WIDTH  instruction word
- `out_valid`  out  CHANNELS  bit c: channel c FIFO non-empty
- `out_ready`  in  CHANNELS  bit c: receiver c consumes head
- `out_instr`  out  CHANNELS*WIDTH  channel c head at bits [c*WIDTH +: WIDTH]
- `sel_err`  out  1  one-cycle pulse: illegal select was dropped

## Operation
- Accept = `in_valid && in_ready`. Pop c = `out_valid[c] && out_ready[c]`.
- Unicast (`in_bcast`=0, `in_sel`<CHANNELS): `in_ready` = !full[in_sel]. On accept, push to FIFO `in_sel` only.
- Broadcast (`in_bcast`=1): `in_ready` = no FIFO is full. On accept, push the same word into every FIFO in the same cycle.
- Illegal select (`in_bcast`=0, `in_sel`≥CHANNELS): `in_ready`=1. The word is consumed and discarded, and `sel_err` pulses high in the next cycle. No FIFO changes.
- Each FIFO keeps read/write pointers of log2(DEPTH)+1 bits. Wrap-around is natural modulo 2·DEPTH.
  - empty = pointers equal
  - full = index bits equal and MSB differs
- Full FIFO: push is blocked by `in_ready`=0, even if the same channel pops that cycle. There is no same-cycle pass-through on full.
- Push and pop on the same channel in the same cycle, when not full: both take effect and the occupancy is unchanged.
- `out_instr` slice c equals the FIFO head while `out_valid[c]`=1, and is forced to 0 while empty.
- Order is preserved per channel. There is no ordering guarantee across channels.
- Combinational paths:
  - `in_ready` depends on `in_sel`/`in_bcast` and on registered full flags only. It never depends on `out_ready`.
  - `out_valid` is registered state only.

## Timing
- Reset (`rst_n`=0 at a clock edge) clears all pointers. After that edge:
  - `out_valid`=0
  - `out_instr`=0
  - `sel_err`=0
  - `in_ready` follows the rules above (1 for legal selects)
- Reset mid-operation discards all queued words; memory contents are not cleared. Inputs are ignored during any cycle in which `rst_n`=0.
- Latency: a word accepted at edge N appears at the FIFO head, with `out_valid[c]`=1, after edge N (visible in cycle N+1) if the FIFO was empty.
- Throughput: one accept per cycle, and one pop per channel per cycle.
- `sel_err` is high for exactly one cycle per dropped word. Back-to-back illegal words give back-to-back pulses.

## Structure
- Shared package `router_pkg` holds:
  - channel index constants `CH_SELF`=0, `CH_LEFT`=1, `CH_RIGHT`=2
  - the pointer-width function
- One sub-module, `route_fifo` (`WIDTH`, `DEPTH`; clk, rst_n, push, din, pop, dout, empty, full), instantiated `CHANNELS` times in a generate loop.
- The top level contains only the select decode, ready logic, broadcast fan-out and `sel_err` register.
- Estimated size: ~250 lines of RTL.

## Test plan
- Reset then unicast: hold `out_ready`=0 and send 0xA5A5_0001 with `in_sel`=2. Required: `out_valid`=3'b100 in the next cycle, slice 2 = 0xA5A5_0001, slices 0/1 = 0.
- Fill and back-pressure: send 5 words to channel 1 with DEPTH=4 and `out_ready`=0. Required: `in_ready`=0 on the 5th word. After one pop, the 5th word is accepted, and the words drain in order 1..5.
- Broadcast: with channel 0 full, assert `in_bcast`. Required: `in_ready`=0. Pop one word from channel 0, then 0xDEAD_BEEF is accepted and appears on all three channels.
- Illegal select: `in_sel`=3 with CHANNELS=3, word 0x1234. Required: `in_ready`=1, `sel_err` pulses for exactly 1 cycle, and `out_valid` is unchanged.
- Simultaneous push/pop plus wrap: stream 20 words into channel 0 with `out_ready[0]`=1 every cycle. Required: every word is output in order, occupancy stays ≤1, and the pointers wrap without loss.
- Reset mid-stream: with 3 words queued on channel 2, drive `rst_n`=0 for 1 cycle. Required: `out_valid`=0 and `out_instr`=0 in the next cycle, and the next pushed word is the first output.
